// File: rtl/uart_mmio_pkg.sv
// Shared definitions for the UART-to-MMIO bridge: host command and response
// codes, the bridge FSM state encoding, and byte insert/select helpers used
// to assemble and emit 32-bit fields LSB first.
package uart_mmio_pkg;

  localparam logic [7:0] CMD_WR  = 8'h01;
  localparam logic [7:0] CMD_RD  = 8'h02;
  localparam logic [7:0] RSP_ACK = 8'hA5;
  localparam logic [7:0] RSP_ERR = 8'hEE;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    GET_ADDR = 3'd1,
    GET_DATA = 3'd2,
    WR       = 3'd3,
    RD_REQ   = 3'd4,
    RD_CAP   = 3'd5,
    SEND     = 3'd6
  } state_t;

  // Place byte b into lane idx of word, leaving the other lanes untouched.
  function automatic logic [31:0] insert_byte(input logic [31:0] word,
                                              input logic [1:0]  idx,
                                              input logic [7:0]  b);
    logic [31:0] res;
    res = word;
    case (idx)
      2'd0:    res[7:0]   = b;
      2'd1:    res[15:8]  = b;
      2'd2:    res[23:16] = b;
      2'd3:    res[31:24] = b;
      default: res = word;
    endcase
    return res;
  endfunction

  // Extract lane idx of word.
  function automatic logic [7:0] select_byte(input logic [31:0] word,
                                             input logic [1:0]  idx);
    logic [7:0] res;
    case (idx)
      2'd0:    res = word[7:0];
      2'd1:    res = word[15:8];
      2'd2:    res = word[23:16];
      2'd3:    res = word[31:24];
      default: res = 8'h00;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/uart_rx.sv
// 8N1 UART receiver with a small byte FIFO so that bytes arriving while the
// consumer is busy stay pending.
// Ports: clk_i/rst_n_i clock and async active-low reset; baud_div_i clocks
// per bit (0 treated as 1); rx_i serial line; done_o high while a byte is
// available; data_o the oldest byte; init_i consumer acknowledge -- one byte
// is popped per init_i assertion and done_o stays low until init_i drops.
module uart_rx #(
  parameter int DEPTH = 8
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic [31:0] baud_div_i,
  input  logic        rx_i,
  input  logic        init_i,
  output logic [7:0]  data_o,
  output logic        done_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  typedef enum logic [1:0] {RX_IDLE = 2'd0, RX_START = 2'd1, RX_DATA = 2'd2, RX_STOP = 2'd3} rx_state_t;

  rx_state_t     st_r, st_n;
  logic          rx_meta_r, rx_sync_r;
  logic [31:0]   div_s, half_s, baud_r, baud_n;
  logic [2:0]    bit_r, bit_n;
  logic [7:0]    shift_r, shift_n;
  logic          push_s, push_ok_s, pop_s;
  logic [7:0]    mem_r [DEPTH];
  logic [AW-1:0] wptr_r, rptr_r;
  logic [AW:0]   count_r;
  logic          ack_r;

  assign div_s     = (baud_div_i == 32'd0) ? 32'd1 : baud_div_i;
  assign half_s    = div_s >> 1;
  assign push_ok_s = push_s && (count_r != FULL);
  assign pop_s     = init_i && !ack_r && (count_r != '0);
  assign data_o    = mem_r[rptr_r];
  assign done_o    = (count_r != '0) && !ack_r;

  // Two-flop synchroniser on the asynchronous serial input.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      rx_meta_r <= 1'b1;
      rx_sync_r <= 1'b1;
    end else begin
      rx_meta_r <= rx_i;
      rx_sync_r <= rx_meta_r;
    end
  end

  // Bit sequencing: confirm start at half a bit, then sample mid-bit.
  always_comb begin
    st_n    = st_r;
    baud_n  = baud_r;
    bit_n   = bit_r;
    shift_n = shift_r;
    push_s  = 1'b0;
    case (st_r)
      RX_IDLE: begin
        baud_n = 32'd0;
        bit_n  = 3'd0;
        if (!rx_sync_r) begin
          st_n = RX_START;
        end else begin
          st_n = RX_IDLE;
        end
      end
      RX_START: begin
        if (baud_r >= half_s) begin
          baud_n = 32'd0;
          st_n   = rx_sync_r ? RX_IDLE : RX_DATA;
        end else begin
          baud_n = baud_r + 32'd1;
        end
      end
      RX_DATA: begin
        if (baud_r >= div_s - 32'd1) begin
          baud_n  = 32'd0;
          shift_n = {rx_sync_r, shift_r[7:1]};
          if (bit_r == 3'd7) begin
            st_n = RX_STOP;
          end else begin
            bit_n = bit_r + 3'd1;
          end
        end else begin
          baud_n = baud_r + 32'd1;
        end
      end
      RX_STOP: begin
        if (baud_r >= div_s - 32'd1) begin
          baud_n = 32'd0;
          push_s = rx_sync_r;  // framing error drops the byte
          st_n   = RX_IDLE;
        end else begin
          baud_n = baud_r + 32'd1;
        end
      end
      default: begin
        st_n   = RX_IDLE;
        baud_n = 32'd0;
      end
    endcase
  end

  // Receiver state register.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      st_r    <= RX_IDLE;
      baud_r  <= 32'd0;
      bit_r   <= 3'd0;
      shift_r <= 8'h00;
    end else begin
      st_r    <= st_n;
      baud_r  <= baud_n;
      bit_r   <= bit_n;
      shift_r <= shift_n;
    end
  end

  // Byte FIFO and acknowledge tracking.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= 8'h00;
      end
      wptr_r  <= '0;
      rptr_r  <= '0;
      count_r <= '0;
      ack_r   <= 1'b0;
    end else begin
      if (push_ok_s) begin
        mem_r[wptr_r] <= shift_r;
        wptr_r        <= wptr_r + 1'b1;
      end
      if (pop_s) begin
        rptr_r <= rptr_r + 1'b1;
      end
      case ({push_ok_s, pop_s})
        2'b10:   count_r <= count_r + 1'b1;
        2'b01:   count_r <= count_r - 1'b1;
        default: count_r <= count_r;
      endcase
      if (pop_s) begin
        ack_r <= 1'b1;
      end else if (!init_i) begin
        ack_r <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/uart_tx.sv
// 8N1 UART transmitter.
// Ports: clk_i/rst_n_i clock and async active-low reset; baud_div_i clocks
// per bit (0 treated as 1); data_i byte to send, sampled when init_i is seen
// while idle; done_o rises after the stop bit and stays high until init_i
// drops; tx_o serial line, idle high.
module uart_tx (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic [31:0] baud_div_i,
  input  logic [7:0]  data_i,
  input  logic        init_i,
  output logic        done_o,
  output logic        tx_o
);

  typedef enum logic [1:0] {TX_IDLE = 2'd0, TX_SHIFT = 2'd1, TX_DONE = 2'd2} tx_state_t;

  tx_state_t   st_r, st_n;
  logic [9:0]  frame_r, frame_n;
  logic [3:0]  bit_r, bit_n;
  logic [31:0] baud_r, baud_n;
  logic        done_r, done_n;
  logic        tx_r, tx_n;
  logic [31:0] div_s;

  assign div_s  = (baud_div_i == 32'd0) ? 32'd1 : baud_div_i;
  assign done_o = done_r;
  assign tx_o   = tx_r;

  // Next-state logic: frame is {stop, data, start} shifted out LSB first.
  always_comb begin
    st_n    = st_r;
    frame_n = frame_r;
    bit_n   = bit_r;
    baud_n  = baud_r;
    done_n  = done_r;
    tx_n    = tx_r;
    case (st_r)
      TX_IDLE: begin
        if (init_i) begin
          frame_n = {1'b1, data_i, 1'b0};
          bit_n   = 4'd0;
          baud_n  = 32'd0;
          tx_n    = 1'b0;
          st_n    = TX_SHIFT;
        end else begin
          tx_n = 1'b1;
        end
      end
      TX_SHIFT: begin
        if (baud_r >= div_s - 32'd1) begin
          baud_n = 32'd0;
          if (bit_r == 4'd9) begin
            st_n   = TX_DONE;
            done_n = 1'b1;
            tx_n   = 1'b1;
          end else begin
            bit_n   = bit_r + 4'd1;
            frame_n = {1'b1, frame_r[9:1]};
            tx_n    = frame_r[1];
          end
        end else begin
          baud_n = baud_r + 32'd1;
        end
      end
      TX_DONE: begin
        if (!init_i) begin
          done_n = 1'b0;
          st_n   = TX_IDLE;
        end else begin
          done_n = 1'b1;
        end
      end
      default: begin
        st_n   = TX_IDLE;
        done_n = 1'b0;
        tx_n   = 1'b1;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      st_r    <= TX_IDLE;
      frame_r <= 10'h3FF;
      bit_r   <= 4'd0;
      baud_r  <= 32'd0;
      done_r  <= 1'b0;
      tx_r    <= 1'b1;
    end else begin
      st_r    <= st_n;
      frame_r <= frame_n;
      bit_r   <= bit_n;
      baud_r  <= baud_n;
      done_r  <= done_n;
      tx_r    <= tx_n;
    end
  end

endmodule

// File: rtl/uart_mmio_bridge.sv
// UART-to-MMIO bridge: a host drives 32-bit reads and writes over a serial
// link. Write frame 0x01 addr[4] data[4] -> 0xA5; read frame 0x02 addr[4]
// -> data[4]; anything else -> 0xEE. Fields are LSB first.
// Ports: clk_i, rst_n_i (async active-low); rx_i/tx_o serial link;
// baud_div_i clocks per bit; rd_addr_o/rd_data_io read port (data sampled one
// cycle after the address, never driven here); wr_addr_o/wr_data_o/
// wr_byte_en_o write port, strobed for exactly one cycle per write.
// Both address outputs rest at IDLE_ADDR when no access is in progress.
module uart_mmio_bridge
  import uart_mmio_pkg::*;
#(
  parameter int unsigned     XLEN      = 32,
  parameter logic [XLEN-1:0] IDLE_ADDR = 32'hFFFF_FF00,
  parameter int unsigned     TIMEOUT   = 1_000_000
) (
  input  logic                     clk_i,
  input  logic                     rst_n_i,
  input  logic                     rx_i,
  output logic                     tx_o,
  input  logic [31:0]              baud_div_i,
  output logic [XLEN-1:0]          rd_addr_o,
  inout  wire  [XLEN-1:0]          rd_data_io,
  output logic [XLEN-1:0]          wr_addr_o,
  output logic [XLEN-1:0]          wr_data_o,
  output logic [$clog2(XLEN)-1:0]  wr_byte_en_o
);

  localparam int          BE_W     = $clog2(XLEN);
  localparam logic [31:0] TMO_LAST = 32'(TIMEOUT - 1);

  state_t            state_r, state_n;
  logic [1:0]        cnt_r, cnt_n;
  logic [31:0]       tmo_r, tmo_n;
  logic [XLEN-1:0]   addr_r, addr_n, data_r, data_n, rsp_r, rsp_n;
  logic              is_rd_r, is_rd_n;
  logic [1:0]        rsp_last_r, rsp_last_n;
  logic              rx_init_r, rx_init_n, tx_init_r, tx_init_n;
  logic [7:0]        tx_data_r, tx_data_n;
  logic [XLEN-1:0]   rd_addr_n, wr_addr_n, wr_data_n;
  logic [BE_W-1:0]   wr_be_n;
  logic [7:0]        rx_data_s;
  logic              rx_done_s, tx_done_s, rx_take_s, accepting_s;

  uart_rx #(.DEPTH(8)) u_rx (
    .clk_i      (clk_i),
    .rst_n_i    (rst_n_i),
    .baud_div_i (baud_div_i),
    .rx_i       (rx_i),
    .init_i     (rx_init_r),
    .data_o     (rx_data_s),
    .done_o     (rx_done_s)
  );

  uart_tx u_tx (
    .clk_i      (clk_i),
    .rst_n_i    (rst_n_i),
    .baud_div_i (baud_div_i),
    .data_i     (tx_data_r),
    .init_i     (tx_init_r),
    .done_o     (tx_done_s),
    .tx_o       (tx_o)
  );

  // Bytes are only pulled from the receiver while parsing; in the access and
  // response states they stay queued inside uart_rx.
  assign accepting_s = (state_r == IDLE) || (state_r == GET_ADDR) || (state_r == GET_DATA);
  assign rx_take_s   = rx_done_s && !rx_init_r && accepting_s;

  // Next-state, datapath and handshake logic.
  always_comb begin
    state_n    = state_r;
    cnt_n      = cnt_r;
    tmo_n      = tmo_r;
    addr_n     = addr_r;
    data_n     = data_r;
    rsp_n      = rsp_r;
    is_rd_n    = is_rd_r;
    rsp_last_n = rsp_last_r;
    tx_init_n  = tx_init_r;
    tx_data_n  = tx_data_r;

    // init stays high from the latch until done falls, so each byte is taken once.
    if (rx_take_s) begin
      rx_init_n = 1'b1;
    end else if (rx_init_r && !rx_done_s) begin
      rx_init_n = 1'b0;
    end else begin
      rx_init_n = rx_init_r;
    end

    case (state_r)
      IDLE: begin
        cnt_n = 2'd0;
        tmo_n = 32'd0;
        if (rx_take_s) begin
          if (rx_data_s == CMD_WR) begin
            is_rd_n = 1'b0;
            state_n = GET_ADDR;
          end else if (rx_data_s == CMD_RD) begin
            is_rd_n = 1'b1;
            state_n = GET_ADDR;
          end else begin
            rsp_n      = {24'h000000, RSP_ERR};
            rsp_last_n = 2'd0;
            state_n    = SEND;
          end
        end else begin
          state_n = IDLE;
        end
      end
      GET_ADDR, GET_DATA: begin
        if (rx_take_s) begin
          tmo_n = 32'd0;
          cnt_n = cnt_r + 2'd1;
          if (state_r == GET_ADDR) begin
            addr_n = insert_byte(addr_r, cnt_r, rx_data_s);
          end else begin
            data_n = insert_byte(data_r, cnt_r, rx_data_s);
          end
          if (cnt_r == 2'd3) begin
            if (state_r == GET_DATA) begin
              state_n = WR;
            end else begin
              state_n = is_rd_r ? RD_REQ : GET_DATA;
            end
          end else begin
            state_n = state_r;
          end
        end else if (tmo_r >= TMO_LAST) begin
          // Silent abort: no access, no response.
          tmo_n   = 32'd0;
          cnt_n   = 2'd0;
          state_n = IDLE;
        end else begin
          tmo_n = tmo_r + 32'd1;
        end
      end
      WR: begin
        rsp_n      = {24'h000000, RSP_ACK};
        rsp_last_n = 2'd0;
        cnt_n      = 2'd0;
        state_n    = SEND;
      end
      RD_REQ: begin
        state_n = RD_CAP;
      end
      RD_CAP: begin
        // Sampled as-is; undriven bits are not treated as an error.
        rsp_n      = rd_data_io;
        rsp_last_n = 2'd3;
        cnt_n      = 2'd0;
        state_n    = SEND;
      end
      SEND: begin
        if (!tx_init_r && !tx_done_s) begin
          tx_init_n = 1'b1;
          tx_data_n = select_byte(rsp_r, cnt_r);
        end else if (tx_init_r && tx_done_s) begin
          tx_init_n = 1'b0;
          cnt_n     = cnt_r + 2'd1;
          if (cnt_r == rsp_last_r) begin
            state_n = IDLE;
          end else begin
            state_n = SEND;
          end
        end else begin
          tx_init_n = tx_init_r;
        end
      end
      default: begin
        state_n   = IDLE;
        cnt_n     = 2'd0;
        tmo_n     = 32'd0;
        tx_init_n = 1'b0;
      end
    endcase

    // Bus outputs are registered from the next state so each strobe lines
    // up exactly with the cycle the FSM spends in WR or RD_REQ.
    if (state_n == WR) begin
      wr_addr_n = addr_n;
      wr_data_n = data_n;
      wr_be_n   = {BE_W{1'b1}};
    end else begin
      wr_addr_n = IDLE_ADDR;
      wr_data_n = {XLEN{1'b0}};
      wr_be_n   = {BE_W{1'b0}};
    end
    if (state_n == RD_REQ) begin
      rd_addr_n = addr_n;
    end else begin
      rd_addr_n = IDLE_ADDR;
    end
  end

  // State, datapath and output registers.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_r      <= IDLE;
      cnt_r        <= 2'd0;
      tmo_r        <= 32'd0;
      addr_r       <= {XLEN{1'b0}};
      data_r       <= {XLEN{1'b0}};
      rsp_r        <= {XLEN{1'b0}};
      is_rd_r      <= 1'b0;
      rsp_last_r   <= 2'd0;
      rx_init_r    <= 1'b0;
      tx_init_r    <= 1'b0;
      tx_data_r    <= 8'h00;
      rd_addr_o    <= IDLE_ADDR;
      wr_addr_o    <= IDLE_ADDR;
      wr_data_o    <= {XLEN{1'b0}};
      wr_byte_en_o <= {BE_W{1'b0}};
    end else begin
      state_r      <= state_n;
      cnt_r        <= cnt_n;
      tmo_r        <= tmo_n;
      addr_r       <= addr_n;
      data_r       <= data_n;
      rsp_r        <= rsp_n;
      is_rd_r      <= is_rd_n;
      rsp_last_r   <= rsp_last_n;
      rx_init_r    <= rx_init_n;
      tx_init_r    <= tx_init_n;
      tx_data_r    <= tx_data_n;
      rd_addr_o    <= rd_addr_n;
      wr_addr_o    <= wr_addr_n;
      wr_data_o    <= wr_data_n;
      wr_byte_en_o <= wr_be_n;
    end
  end

endmodule

// File: doc/uart_mmio_bridge.md
UART_MMIO_BRIDGE -- requirements
Module: uart_mmio_bridge

Interface
REQ-001 Parameter XLEN, default 32: MMIO address/data width; only 32 is supported.
REQ-002 Parameter IDLE_ADDR, default 32'hFFFF_FF00: address driven on rd_addr_o/wr_addr_o when no access is in progress; must be unmapped.
REQ-003 Parameter TIMEOUT, default 1_000_000: inter-byte timeout, in clk_i cycles.
REQ-004 clk_i  input  1  single clock for the whole block.
REQ-005 rst_n_i  input  1  reset, asynchronous, active-low.
REQ-006 rx_i  input  1  UART serial in, from the host.
REQ-007 tx_o  output  1  UART serial out, to the host.
REQ-008 baud_div_i  input  32  baud divider, passed unchanged to both UART sub-blocks.
REQ-009 rd_addr_o  output  XLEN  MMIO read address; the bridge is the bus initiator.
REQ-010 rd_data_io  inout  XLEN  MMIO read data, tri-state bus driven by slaves; the bridge SHALL never drive it.
REQ-011 wr_addr_o  output  XLEN  MMIO write address.
REQ-012 wr_data_o  output  XLEN  MMIO write data.
REQ-013 wr_byte_en_o  output  $clog2(XLEN)  write enable; any nonzero value means a write; all-ones when writing.

Function
REQ-014 Host protocol, all multi-byte fields LSB first:
- Write frame: 0x01, addr[4], data[4]. Response: 0xA5.
- Read frame: 0x02, addr[4]. Response: data[4].
REQ-015 Any other command byte SHALL return 0xEE and go to IDLE without any MMIO access.
REQ-016 FSM states: IDLE, GET_ADDR, GET_DATA, WR, RD_REQ, RD_CAP, SEND.
REQ-017 Transitions:
- IDLE to GET_ADDR on a valid command byte.
- GET_ADDR, after 4 bytes: to GET_DATA for a write, to RD_REQ for a read.
- GET_DATA to WR after 4 bytes.
- WR, RD_REQ and RD_CAP each last exactly 1 cycle.
- RD_REQ to RD_CAP; WR and RD_CAP to SEND.
- SEND to IDLE after the last response byte completes.
REQ-018 A 2-bit byte counter SHALL index the fields; it wraps 3 to 0 on each field completion.
REQ-019 RX handshake: when uart_rx done_o=1, latch data_o and assert init_i; hold init_i until done_o falls; a byte is consumed exactly once.
REQ-020 TX handshake: present the byte on data_i and assert init_i; deassert init_i in the cycle after done_o=1; the next byte waits until the handshake completes.
REQ-021 WR cycle: exactly one clock with wr_addr_o=addr, wr_data_o=data, wr_byte_en_o all-ones. In every other cycle, wr_byte_en_o=0 and wr_addr_o=IDLE_ADDR.
REQ-022 RD_REQ: rd_addr_o=addr for exactly one clock. RD_CAP: sample rd_data_io into the response register (1-cycle slave latency). In every other cycle, rd_addr_o=IDLE_ADDR.
REQ-023 Timeout: in GET_ADDR or GET_DATA, TIMEOUT cycles with no received byte SHALL abort to IDLE with no MMIO access and no response. The counter clears on every received byte.
REQ-024 Bytes arriving during WR, RD_REQ, RD_CAP or SEND SHALL remain pending in uart_rx and are parsed after the return to IDLE.
REQ-025 A read that returns Z/X bits SHALL send the sampled value as-is; no bus error is signalled.

Reset
REQ-026 Values while rst_n_i=0:
- FSM=IDLE, byte counter=0, timeout counter=0.
- addr/data/response registers=0.
- rd_addr_o=wr_addr_o=IDLE_ADDR, wr_data_o=0, wr_byte_en_o=0.
- tx_o=1 (idle line).
REQ-027 Reset asserted mid-frame or mid-response SHALL abandon the transaction immediately; no partial MMIO write SHALL occur after deassertion.
REQ-028 Both UART sub-blocks SHALL be reset by rst_n_i.

Structure
REQ-029 Package uart_mmio_pkg SHALL hold:
- command codes CMD_WR=8'h01, CMD_RD=8'h02.
- response codes RSP_ACK=8'hA5, RSP_ERR=8'hEE.
- the FSM state enum.
REQ-030 The block SHALL instantiate the existing uart_rx and uart_tx; no new sub-module.

Verification
REQ-031 Write: host sends 01 00 00 00 40 78 56 34 12 -> one cycle with wr_addr_o=32'h4000_0000, wr_data_o=32'h1234_5678, wr_byte_en_o all-ones; then tx 0xA5.
REQ-032 Read: slave model returns 32'hDEAD_BEEF one cycle after rd_addr_o=32'h4000_0004; host sends 02 04 00 00 40 -> tx EF BE AD DE.
REQ-033 Bad command: host sends 0x7F -> tx 0xEE; no write pulse; rd_addr_o stays IDLE_ADDR.
REQ-034 Timeout: TIMEOUT=1000; host sends 01 00 00, then waits 1000 cycles, then sends a full read frame -> no write occurs; the read completes normally.
REQ-035 Reset: rst_n_i pulsed low after the 6th byte of a write frame -> outputs return to reset values; no wr_byte_en_o pulse afterwards.
REQ-036 Back-to-back: a read frame immediately after a write frame, with no gap -> both complete in order, responses A5 then 4 data bytes.
